// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Arbiter state encoding and frame timing constants.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_GAP    = 2'd3
  } arb_state_t;

  localparam int UART_FRAME_BITS = 10;
  localparam int UART_TX_LATENCY = 11;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid at or after ptr.
// Ports: req_valid/ptr in; one-hot grant, grant_idx, any_valid out.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int W     = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [W-1:0]     ptr,
  output logic [N_REQ-1:0] grant,
  output logic [W-1:0]     grant_idx,
  output logic             any_valid
);

  always_comb begin : pick
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    // Scan farthest offset first so the nearest valid wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        grant     = '0;
        grant[idx] = 1'b1;
        grant_idx = W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte sources.
// REQ_* handshake in, TX_DIN/TX_ENA/TX_DONE to uart_tx, BUSY/GRANT_ID/TIMEOUT_ERR status.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 31
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [N_REQ-1:0]         REQ_VALID,
  input  logic [8*N_REQ-1:0]       REQ_DATA,
  output logic [N_REQ-1:0]         REQ_READY,
  output logic [7:0]               TX_DIN,
  output logic                     TX_ENA,
  input  logic                     TX_DONE,
  output logic                     BUSY,
  output logic [$clog2(N_REQ)-1:0] GRANT_ID,
  output logic                     TIMEOUT_ERR
);

  localparam int W   = $clog2(N_REQ);
  localparam int WCW = $clog2(TIMEOUT + 1);

  arb_state_t       state;
  arb_state_t       state_d;
  logic [W-1:0]     ptr;
  logic [WCW-1:0]   wait_cnt;
  logic [3:0]       gap_cnt;
  logic [N_REQ-1:0] pk_grant;
  logic [W-1:0]     pk_idx;
  logic             pk_any;
  logic [7:0]       pk_data;
  logic             wait_hit;
  logic             gap_end;

  rr_pick #(
    .N_REQ(N_REQ),
    .W    (W)
  ) u_pick (
    .req_valid(REQ_VALID),
    .ptr      (ptr),
    .grant    (pk_grant),
    .grant_idx(pk_idx),
    .any_valid(pk_any)
  );

  assign pk_data  = REQ_DATA[8*pk_idx +: 8];
  // Hit on the cycle the count would reach TIMEOUT.
  assign wait_hit = (int'(wait_cnt) >= TIMEOUT - 1);
  assign gap_end  = (int'(gap_cnt) + 1 >= GAP_CYCLES);

  // Ready is masked during reset since state is only cleared, not gated.
  assign REQ_READY = (RESET && state == S_IDLE) ? pk_grant : '0;

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:   if (pk_any) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (TX_DONE || wait_hit) state_d = S_GAP;
      S_GAP:    if (gap_end) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= S_IDLE;
      ptr         <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      TX_DIN      <= 8'h00;
      TX_ENA      <= 1'b0;
      BUSY        <= 1'b0;
      GRANT_ID    <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state  <= state_d;
      BUSY   <= (state_d != S_IDLE);
      TX_ENA <= (state_d == S_LAUNCH);
      if (state == S_IDLE && pk_any) begin
        TX_DIN   <= pk_data;
        GRANT_ID <= pk_idx;
        ptr      <= (int'(pk_idx) == N_REQ - 1) ? '0 : pk_idx + 1'b1;
      end
      unique case (state)
        S_LAUNCH: wait_cnt <= '0;
        S_WAIT: begin
          gap_cnt <= '0;
          if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
          if (!TX_DONE && wait_hit) TIMEOUT_ERR <= 1'b1;
        end
        S_GAP: if (gap_cnt != 4'hF) gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
